// File: rtl/sig_gen_pkg.sv
// Shared types and widths for the audio signal generator command path.
package sig_gen_pkg;

    localparam int unsigned FRAME_BITS = 8;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 5;
    localparam int unsigned TIMEOUT_W  = 12;
    localparam int unsigned BITCNT_W   = $clog2(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } loaderState_t;

    // One register-write transaction as seen on the generator bus.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } regWrite_t;

endpackage

// File: rtl/serial_reg_loader_if.sv
// Register-write bus between the serial loader and the signal generator.
interface serial_reg_loader_if;
    import sig_gen_pkg::*;

    logic              write_strobe;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;

    modport master (output write_strobe, output address, output data);
    modport slave  (input  write_strobe, input  address, input  data);

endinterface

// File: rtl/serial_reg_loader_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin with edge pulses.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic asyncIn,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   prevQ;

    // Synchroniser chain plus one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            syncQ <= '0;
            prevQ <= 1'b0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], asyncIn};
            prevQ <= syncQ[SYNC_STAGES-1];
        end
    end

    assign level  = syncQ[SYNC_STAGES-1];
    assign rise_c =  level & ~prevQ;
    assign fall_c = ~level &  prevQ;

endmodule

// File: rtl/serial_reg_loader.sv
// Serial command front end: frames 8-bit SPI-style words into register writes.
module serial_reg_loader
    import sig_gen_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4095
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scs_n_i,
    input  logic                sclk_i,
    input  logic                sdata_i,
    serial_reg_loader_if.master wrBus,
    output logic                frame_error,
    output logic                busy
);

    logic scsLvl, scsRise, scsFall;
    logic sclkLvl, sclkRise, sclkFall;
    logic sdataLvl, unusedSdataRise, unusedSdataFall;
    logic unusedSclkLvl, unusedSclkFall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncScs (
        .clk(clk), .rst(rst), .asyncIn(scs_n_i),
        .level(scsLvl), .rise_c(scsRise), .fall_c(scsFall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncSclk (
        .clk(clk), .rst(rst), .asyncIn(sclk_i),
        .level(sclkLvl), .rise_c(sclkRise), .fall_c(sclkFall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_syncSdata (
        .clk(clk), .rst(rst), .asyncIn(sdata_i),
        .level(sdataLvl), .rise_c(unusedSdataRise), .fall_c(unusedSdataFall)
    );

    assign unusedSclkLvl  = sclkLvl;
    assign unusedSclkFall = sclkFall;

    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    localparam logic [BITCNT_W-1:0]  LAST_BIT      = BITCNT_W'(FRAME_BITS - 1);

    loaderState_t              state, stateNext;
    logic [FRAME_BITS-1:0]     shiftQ, shiftNext;
    logic [BITCNT_W-1:0]       bitCntQ, bitCntNext;
    logic [TIMEOUT_W-1:0]      toCntQ, toCntNext;
    logic                      issueQ, issueNext;
    logic                      frameErrNext;

    // State, datapath and pending-write registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shiftQ  <= '0;
            bitCntQ <= '0;
            toCntQ  <= '0;
            issueQ  <= 1'b0;
        end else begin
            state   <= stateNext;
            shiftQ  <= shiftNext;
            bitCntQ <= bitCntNext;
            toCntQ  <= toCntNext;
            issueQ  <= issueNext;
        end
    end

    // Next-state logic: framing, bit counting, timeout and error detection.
    always_comb begin
        stateNext    = state;
        shiftNext    = shiftQ;
        bitCntNext   = bitCntQ;
        toCntNext    = toCntQ;
        issueNext    = 1'b0;
        frameErrNext = frame_error;

        unique case (state)
            IDLE: begin
                if (scsFall) begin
                    stateNext    = SHIFT;
                    frameErrNext = 1'b0;
                    shiftNext    = '0;
                    bitCntNext   = '0;
                    toCntNext    = '0;
                end
            end
            SHIFT: begin
                if (sclkRise) begin
                    shiftNext  = {shiftQ[FRAME_BITS-2:0], sdataLvl};
                    bitCntNext = bitCntQ + BITCNT_W'(1);
                    toCntNext  = '0;
                    if (bitCntQ == LAST_BIT) begin
                        // Completed frame wins over a simultaneous deselect.
                        issueNext = 1'b1;
                        stateNext = scsRise ? IDLE : HOLD;
                    end else if (scsRise) begin
                        frameErrNext = 1'b1;
                        stateNext    = IDLE;
                    end
                end else if (scsRise) begin
                    frameErrNext = 1'b1;
                    stateNext    = IDLE;
                end else if (toCntQ >= TIMEOUT_LIMIT) begin
                    frameErrNext = 1'b1;
                    stateNext    = IDLE;
                end else if (toCntQ != '1) begin
                    toCntNext = toCntQ + TIMEOUT_W'(1);
                end
            end
            HOLD: begin
                if (sclkRise) begin
                    frameErrNext = 1'b1;
                end
                if (scsLvl) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Registered outputs; address/data only move together with a strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrBus.write_strobe <= 1'b0;
            wrBus.address      <= '0;
            wrBus.data         <= '0;
            frame_error        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            wrBus.write_strobe <= issueQ;
            if (issueQ) begin
                wrBus.address <= shiftQ[FRAME_BITS-1 -: ADDR_W];
                wrBus.data    <= shiftQ[DATA_W-1:0];
            end
            frame_error <= frameErrNext;
            busy        <= (stateNext != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_reg_loader.sv
// Scoreboard bench for serial_reg_loader: directed frames, monitor checks writes.
module tb_serial_reg_loader;
    import sig_gen_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic scs_n, sclk, sdata;
    logic frameError, busy;

    int checks   = 0;
    int failures = 0;

    regWrite_t expQ[$];

    serial_reg_loader_if bus ();

    serial_reg_loader #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .scs_n_i    (scs_n),
        .sclk_i     (sclk),
        .sdata_i    (sdata),
        .wrBus      (bus.master),
        .frame_error(frameError),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frameStart(input string name);
        scs_n = 1'b0;
        sclk  = 1'b0;
        waitCycles(4);
        check({name, "_busy_open"}, int'(busy), 1);
    endtask

    task automatic sendBit(input logic b);
        sdata = b;
        sclk  = 1'b0;
        waitCycles(4);
        sclk  = 1'b1;
        waitCycles(4);
    endtask

    task automatic sendBits(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            sendBit(v[7-i]);
        end
    endtask

    task automatic frameEnd();
        sclk = 1'b0;
        waitCycles(4);
        scs_n = 1'b1;
        waitCycles(6);
    endtask

    task automatic pushExp(input int a, input int d);
        regWrite_t w;
        w.address = ADDR_W'(a);
        w.data    = DATA_W'(d);
        expQ.push_back(w);
    endtask

    // Monitor: every strobe must match the head of the scoreboard and last one cycle.
    logic prevStrobe = 1'b0;
    always @(negedge clk) begin
        if (bus.write_strobe) begin
            regWrite_t got, exp;
            got.address = bus.address;
            got.data    = bus.data;
            checks++;
            if (prevStrobe) begin
                failures++;
                $display("FAIL strobe_width: strobe high for 2+ cycles, expected 1");
            end else if (expQ.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, expected none",
                         got.address, got.data);
            end else begin
                exp = expQ.pop_front();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL write_payload: got addr=%0d data=%0d expected addr=%0d data=%0d",
                             got.address, got.data, exp.address, exp.data);
                end
            end
        end
        prevStrobe = bus.write_strobe;
    end

    initial begin
        rst   = 1'b1;
        scs_n = 1'b1;
        sclk  = 1'b0;
        sdata = 1'b0;
        waitCycles(3);
        rst = 1'b0;
        waitCycles(1);

        check("rst_strobe", int'(bus.write_strobe), 0);
        check("rst_addr",   int'(bus.address), 0);
        check("rst_data",   int'(bus.data), 0);
        check("rst_err",    int'(frameError), 0);
        check("rst_busy",   int'(busy), 0);
        waitCycles(4);

        // Single clean frame 010_01000.
        pushExp(2, 8);
        frameStart("f1");
        sendBits(8'b010_01000, 8);
        frameEnd();
        check("f1_err",  int'(frameError), 0);
        check("f1_busy", int'(busy), 0);

        // Back-to-back frames; bus holds the last write afterwards.
        pushExp(0, 31);
        frameStart("f2");
        sendBits(8'b000_11111, 8);
        frameEnd();
        pushExp(5, 7);
        frameStart("f3");
        sendBits(8'b101_00111, 8);
        frameEnd();
        waitCycles(5);
        check("hold_addr", int'(bus.address), 5);
        check("hold_data", int'(bus.data), 7);

        // Short frame: 5 bits then deselect.
        frameStart("short");
        sendBits(8'b111_11000, 5);
        frameEnd();
        check("short_err",  int'(frameError), 1);
        check("short_busy", int'(busy), 0);
        waitCycles(10);
        check("short_err_sticky", int'(frameError), 1);

        // Overlong frame: 10 edges, first 8 are 110_00001.
        frameStart("long");
        check("long_err_cleared", int'(frameError), 0);
        pushExp(6, 1);
        sendBits(8'b110_00001, 8);
        check("long_err_after8", int'(frameError), 0);
        sendBit(1'b1);
        check("long_err_after9", int'(frameError), 1);
        sendBit(1'b0);
        frameEnd();
        check("long_err_end", int'(frameError), 1);
        check("long_addr", int'(bus.address), 6);
        check("long_data", int'(bus.data), 1);

        // Timeout: 3 bits then sclk stalls with select still low.
        frameStart("tmo");
        sendBits(8'b101_00000, 3);
        waitCycles(25);
        check("tmo_err",  int'(frameError), 1);
        check("tmo_busy", int'(busy), 0);
        frameEnd();
        pushExp(3, 4);
        frameStart("after_tmo");
        check("after_tmo_err_cleared", int'(frameError), 0);
        sendBits(8'b011_00100, 8);
        frameEnd();
        check("after_tmo_err", int'(frameError), 0);

        // Reset landing one cycle before the strobe would be registered.
        frameStart("rstf");
        sendBits(8'b111_10101, 7);
        sdata = 1'b1;
        sclk  = 1'b0;
        waitCycles(4);
        sclk = 1'b1;
        waitCycles(2);
        rst = 1'b1;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(3);
        frameEnd();
        check("rstf_strobe", int'(bus.write_strobe), 0);
        check("rstf_addr",   int'(bus.address), 0);
        check("rstf_data",   int'(bus.data), 0);
        check("rstf_err",    int'(frameError), 0);
        check("rstf_busy",   int'(busy), 0);

        waitCycles(10);
        check("scoreboard_drained", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_reg_loader.md
# serial_reg_loader

Serial-to-parallel command front end for the audio signal generator. Receives 8-bit frames (3-bit register address, 5-bit data) from three asynchronous input pins using an SPI-style select/clock/data protocol. For each complete frame it drives the generator's `write_strobe` / `address` / `data` register-write bus for exactly one `clk` cycle. It sits directly upstream of `signal_generator` and owns all pin synchronisation, framing and error detection.

## Interface

Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser (minimum 2).
- `TIMEOUT_CYCLES`, 4095: maximum number of `clk` cycles allowed between sclk rising edges inside a frame before the frame is aborted (1..4095, 12-bit counter).

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `scs_n_i`  in  1: frame select, active low, asynchronous to `clk`.
- `sclk_i`  in  1: serial bit clock, asynchronous; data is sampled on its rising edge.
- `sdata_i`  in  1: serial data, MSB first, asynchronous.
- `write_strobe`  out  1: one-cycle pulse; `address`/`data` are valid while it is high.
- `address`  out  3: register address (frame bits 7:5).
- `data`  out  5: register data (frame bits 4:0).
- `frame_error`  out  1: sticky error flag; cleared at the next frame start or by reset.
- `busy`  out  1: high while a frame is open (state SHIFT or HOLD).

## Operation

- All three pins pass through `SYNC_STAGES` flops. Edges are detected on the synchronised signals by comparing each against a one-cycle-delayed copy.
- State machine: IDLE, SHIFT, HOLD.
  - IDLE: on the synchronised falling edge of `scs_n`, clear `frame_error`, bit counter and timeout counter, then go to SHIFT.
  - SHIFT: on each sclk rising edge, shift synchronised `sdata` into an 8-bit register (MSB first) and increment the 3-bit counter.
    - When the 8th bit is shifted in: go to HOLD and issue the write.
    - If `scs_n` goes high with fewer than 8 bits: set `frame_error`, issue no write, go to IDLE.
    - If the timeout counter reaches `TIMEOUT_CYCLES`: set `frame_error`, issue no write, go to IDLE.
  - HOLD: wait for `scs_n` high, then go to IDLE. Any further sclk rising edge in HOLD sets `frame_error`; the write already issued is not retracted. The timeout does not apply in HOLD.
- Write issue: `address` ← shift[7:5] and `data` ← shift[4:0] are registered together with `write_strobe`=1. The strobe drops after one cycle.
- `address` and `data` hold their last written value between frames and never change without a strobe.
- The timeout counter resets on every sclk rising edge and saturates; it does not wrap.

## Timing

- Reset values: `write_strobe`=0, `address`=0, `data`=0, `frame_error`=0, `busy`=0, state IDLE, shift register and counters 0.
- Latency, with `SYNC_STAGES`=2: a pin change first sampled at clk edge k appears synchronised after edge k+1 and is acted on at edge k+2 (bit shifted, state updated). For the 8th bit, `write_strobe`/`address`/`data` are registered at edge k+3 and `write_strobe` is high for the single cycle that follows.
- `busy` rises at the edge that enters SHIFT and falls at the edge that returns to IDLE.
- Simultaneous events:
  - 8th sclk edge and `scs_n` rise detected in the same cycle: the bit is processed first, the write is issued, and the next state is IDLE with no error.
  - `scs_n` falling edge detected while in HOLD: not possible without a preceding rise. `scs_n` must be seen high for at least one synchronised cycle before a new frame starts.
- `rst` mid-frame: the frame is discarded, no strobe is issued, and all state returns to reset values on the next edge. If `rst` is asserted in the cycle a strobe would be registered, the strobe is suppressed.
- Minimum pin timing: each sclk high and low phase must last at least `SYNC_STAGES`+1 `clk` cycles. Faster sclk is out of specification.

## Structure

- Shared package `sig_gen_pkg` holds:
  - state enum {IDLE, SHIFT, HOLD};
  - `FRAME_BITS`=8, `ADDR_W`=3, `DATA_W`=5;
  - `TIMEOUT_W`=12.
  `signal_generator` uses the same `ADDR_W`/`DATA_W`.
- Sub-module `sync_edge`: parameterised `SYNC_STAGES`-deep synchroniser with registered level output plus rise and fall pulse outputs. It is instantiated three times (scs_n, sclk, sdata; the edge outputs on sdata are unused).
- `serial_reg_loader` contains the FSM, shift register, counters and output registers.

## Test plan

- Reset, then frame 0b010_01000 → exactly one `write_strobe` cycle with `address`=2, `data`=8; `frame_error`=0; `busy` low after `scs_n` rises.
- Two back-to-back frames 0b000_11111 then 0b101_00111 → two strobes, (0,31) then (5,7); `address`/`data` hold (5,7) afterwards.
- `scs_n` raised after 5 bits → no strobe; `frame_error`=1, and it stays 1 until the next `scs_n` fall, then clears.
- 10 sclk edges in one frame (first 8 = 0b110_00001) → one strobe with (6,1), `frame_error`=1 after the 9th edge.
- With `TIMEOUT_CYCLES`=20, stall sclk for 25 cycles after 3 bits → `frame_error`=1, `busy`=0, no strobe. A following clean frame 0b011_00100 gives (3,4).
- Assert `rst` one cycle before the strobe would be registered → no strobe; all outputs 0 after reset.
